// File: rtl/dm_cache_wt_pkg.sv
// dm_cache_wt_pkg: FSM states and width helper shared by the cache slice
package dm_cache_wt_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dm_cache_store.sv
// dm_cache_store: data, tag and valid arrays with comb read, line refill and word update ports
module dm_cache_store #(
  parameter int WORD_W = 32,
  parameter int WPL    = 4,
  parameter int LINES  = 16,
  parameter int OFF_W  = 2,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      idx,
  input  logic [OFF_W-1:0]      off,
  input  logic [TAG_W-1:0]      tag,
  output logic                  hit,
  output logic [WORD_W-1:0]     rword,
  input  logic                  line_we,
  input  logic [WORD_W*WPL-1:0] line_data,
  input  logic                  word_we,
  input  logic [WORD_W-1:0]     word_data
);
  logic [WORD_W*WPL-1:0] data_q [LINES];
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  assign hit   = valid_q[idx] && tag_q[idx] == tag;
  assign rword = data_q[idx][off*WORD_W +: WORD_W];
  always_ff @(posedge clk)
    if (reset) valid_q <= '0;
    else begin
      if (line_we) begin
        data_q[idx]  <= line_data;
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
      end
      if (word_we) data_q[idx][off*WORD_W +: WORD_W] <= word_data;
    end
endmodule

// File: rtl/dm_cache_wt.sv
// dm_cache_wt: direct-mapped write-through no-write-allocate cache with stall and mem handshake
module dm_cache_wt
  import dm_cache_wt_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 16,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [WORD_W-1:0]                cpu_wdata,
  input  logic                             cpu_rd,
  input  logic                             cpu_wr,
  output logic [WORD_W-1:0]                cpu_rdata,
  output logic                             cpu_stall,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic                             mem_rd,
  output logic                             mem_wr,
  output logic [WORD_W-1:0]                mem_wdata,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                             mem_ready,
  output logic [CNT_W-1:0]                 hit_cnt,
  output logic [CNT_W-1:0]                 miss_cnt
);
  localparam int OFF_W = clog2(WORDS_PER_LINE);
  localparam int IDX_W = clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  state_t             state;
  logic               replay, hit;
  logic [WORD_W-1:0]  rword;
  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  assign off = cpu_addr[OFF_W-1:0];
  assign idx = cpu_addr[OFF_W +: IDX_W];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  dm_cache_store #(
    .WORD_W(WORD_W), .WPL(WORDS_PER_LINE), .LINES(LINES),
    .OFF_W(OFF_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) u_store (
    .clk(clk), .reset(reset), .idx(idx), .off(off), .tag(tag),
    .hit(hit), .rword(rword),
    .line_we(!reset && state == REFILL && mem_ready), .line_data(mem_rdata),
    .word_we(!reset && state == IDLE && cpu_wr && hit), .word_data(cpu_wdata)
  );
  assign cpu_stall = reset ? 1'b0 :
                     state == IDLE  ? cpu_wr | (cpu_rd & ~hit) :
                     state == WRITE ? ~mem_ready : 1'b1;
  assign cpu_rdata = (!reset && state == IDLE && cpu_rd && !cpu_wr && hit) ? rword : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      replay    <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else
      case (state)
        IDLE:
          if (cpu_wr) begin
            state     <= WRITE;
            mem_wr    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end else if (cpu_rd && hit) begin
            if (!replay && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            replay <= 1'b0;
          end else if (cpu_rd) begin
            state    <= REFILL;
            mem_rd   <= 1'b1;
            mem_addr <= {tag, idx, {OFF_W{1'b0}}};
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
          end
        REFILL:
          if (mem_ready) begin
            state  <= IDLE;
            mem_rd <= 1'b0;
            replay <= 1'b1;
          end
        WRITE:
          if (mem_ready) begin
            state  <= IDLE;
            mem_wr <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dm_cache_wt.sv
// tb_dm_cache_wt: directed and random checks of dm_cache_wt against a line-ownership cache model
module tb_dm_cache_wt;
  logic         clk = 0, reset = 1;
  logic [9:0]   cpu_addr = '0, mem_addr;
  logic [31:0]  cpu_wdata = '0, cpu_rdata, mem_wdata;
  logic         cpu_rd = 0, cpu_wr = 0, cpu_stall, mem_rd, mem_wr, mem_ready = 0;
  logic [127:0] mem_rdata = '0;
  logic [3:0]   hit_cnt, miss_cnt;
  int errs = 0, checks = 0;
  logic [31:0] mem_m [1024];
  logic [7:0]  line_m [16];
  bit          vld_m [16];
  int          hits_m = 0, misses_m = 0;

  dm_cache_wt #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input logic [9:0] a);
    return vld_m[a[5:2]] && line_m[a[5:2]] == a[9:2];
  endfunction

  task automatic check_cnts(input string tag);
    check({tag, "_hits"}, 32'(hit_cnt), 32'(hits_m));
    check({tag, "_misses"}, 32'(miss_cnt), 32'(misses_m));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1; cpu_rd = 0; cpu_wr = 0; mem_ready = 0;
    @(negedge clk);
    check("rst_stall", 32'(cpu_stall), 0);
    check("rst_rdata", cpu_rdata, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_memrd", 32'(mem_rd), 0);
    check("rst_memwr", 32'(mem_wr), 0);
    foreach (vld_m[i]) vld_m[i] = 0;
    hits_m = 0; misses_m = 0;
    check_cnts("rst");
  endtask

  task automatic do_rd(input logic [9:0] a, input int wait_n);
    bit h = m_hit(a);
    @(posedge clk); #1 cpu_addr = a; cpu_rd = 1; cpu_wr = 0; mem_ready = 0;
    @(negedge clk);
    if (h) begin
      check("hit_stall", 32'(cpu_stall), 0);
      check("hit_data", cpu_rdata, mem_m[a]);
      if (hits_m < 15) hits_m++;
    end else begin
      check("miss_stall", 32'(cpu_stall), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("refill_rd", 32'(mem_rd), 1);
      check("refill_wr", 32'(mem_wr), 0);
      check("refill_addr", 32'(mem_addr), 32'({a[9:2], 2'b00}));
      repeat (wait_n) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("refill_wait_stall", 32'(cpu_stall), 1);
        check("refill_wait_rd", 32'(mem_rd), 1);
      end
      @(posedge clk); #1 mem_ready = 1;
      mem_rdata = {mem_m[{a[9:2], 2'd3}], mem_m[{a[9:2], 2'd2}], mem_m[{a[9:2], 2'd1}], mem_m[{a[9:2], 2'd0}]};
      @(negedge clk);
      check("refill_ready_stall", 32'(cpu_stall), 1);
      @(posedge clk); #1 mem_ready = 0; mem_rdata = '0;
      @(negedge clk);
      check("replay_stall", 32'(cpu_stall), 0);
      check("replay_data", cpu_rdata, mem_m[a]);
      vld_m[a[5:2]] = 1; line_m[a[5:2]] = a[9:2];
      if (misses_m < 15) misses_m++;
    end
    @(posedge clk); #1 cpu_rd = 0;
    @(negedge clk);
    check("rd_done_memrd", 32'(mem_rd), 0);
    check("rd_idle_rdata", cpu_rdata, 0);
    check_cnts("rd");
  endtask

  task automatic do_wr(input logic [9:0] a, input logic [31:0] d, input int wait_n, input bit rd_too);
    @(posedge clk); #1 cpu_addr = a; cpu_wdata = d; cpu_wr = 1; cpu_rd = rd_too; mem_ready = 0;
    @(negedge clk);
    check("wr_stall", 32'(cpu_stall), 1);
    check("wr_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_memwr", 32'(mem_wr), 1);
    check("wr_memrd", 32'(mem_rd), 0);
    check("wr_addr", 32'(mem_addr), 32'(a));
    check("wr_wdata", mem_wdata, d);
    check("wr_hold_stall", 32'(cpu_stall), 1);
    repeat (wait_n) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("wr_wait_stall", 32'(cpu_stall), 1);
      check("wr_wait_memwr", 32'(mem_wr), 1);
    end
    @(posedge clk); #1 mem_ready = 1;
    @(negedge clk);
    check("wr_ready_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1 mem_ready = 0; cpu_wr = 0; cpu_rd = 0;
    @(negedge clk);
    check("wr_done_memwr", 32'(mem_wr), 0);
    check("wr_done_memrd", 32'(mem_rd), 0);
    mem_m[a] = d;
    check_cnts("wr");
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = $urandom;
    foreach (vld_m[i]) vld_m[i] = 0;
    do_reset();
    // cold miss, replay, then neighbouring-word hit
    do_rd(10'h005, 3);
    check("t1_miss", 32'(miss_cnt), 1);
    check("t1_hit0", 32'(hit_cnt), 0);
    do_rd(10'h006, 0);
    check("t1_hit1", 32'(hit_cnt), 1);
    do_wr(10'h005, 32'hDEADBEEF, 2, 0);
    do_rd(10'h005, 0);
    check("t2_hits", 32'(hit_cnt), 2);
    do_wr(10'h105, $urandom, 1, 0);
    do_rd(10'h105, 1);
    check("t3_miss", 32'(miss_cnt), 2);
    do_reset();
    do_rd(10'h005, 0);
    do_rd(10'h045, 1);
    do_rd(10'h005, 2);
    check("t4_miss", 32'(miss_cnt), 3);
    // reset in the second refill cycle abandons the request and invalidates lines
    @(posedge clk); #1 cpu_addr = 10'h205; cpu_rd = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("t5_rst_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1 reset = 0; cpu_rd = 0; mem_ready = 1;
    @(negedge clk);
    check("t5_memrd", 32'(mem_rd), 0);
    @(posedge clk); #1 mem_ready = 0;
    @(negedge clk);
    check("t5_late_ready", 32'(mem_rd | mem_wr), 0);
    foreach (vld_m[i]) vld_m[i] = 0;
    hits_m = 0; misses_m = 0;
    do_rd(10'h005, 0);
    check("t5_miss", 32'(miss_cnt), 1);
    do_reset();
    for (int i = 0; i < 20; i++) do_rd(10'((i << 2) + ((i >> 4) << 6)), 0);
    check("t6_sat", 32'(miss_cnt), 15);
    do_wr(10'h300, 32'h12345678, 0, 1);
    for (int n = 0; n < 200; n++) begin
      logic [9:0] a = {$urandom_range(0, 3) == 0 ? 2'b01 : 2'b00, 2'b00, 6'($urandom_range(0, 63))};
      if (n % 50 == 49) do_reset();
      if ($urandom_range(0, 2) == 0) do_wr(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      else do_rd(a, $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
